// File: rtl/inv_mix_columns_seq_pkg.sv
// inv_mix_columns_seq_pkg: shared AES types, constants and GF(2^8) helpers
package inv_mix_columns_seq_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;
    typedef logic [1:0]   col_idx_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam byte_t AES_POLY = 8'h1B;
    localparam int    NUM_COLS = 4;
    localparam int    COL_W    = 32;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic word_t get_col(input state_t s, input col_idx_t c);
        return s[127 - COL_W * int'(c) -: COL_W];
    endfunction

endpackage

// File: rtl/inv_mix_word.sv
// inv_mix_word: combinational InvMixColumns on one 32-bit column, byte 0 at MSB
module inv_mix_word
    import inv_mix_columns_seq_pkg::*;
(
    input  word_t w,
    output word_t y
);

    byte_t b [4];
    byte_t x2 [4];
    byte_t x4 [4];
    byte_t x8 [4];
    byte_t o [4];

    // 0e=8^4^2, 0b=8^2^1, 0d=8^4^1, 09=8^1; each output row is the circulant shift of the previous
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            b[i]  = w[31 - 8 * i -: 8];
            x2[i] = xtime(b[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int r = 0; r < 4; r++)
            o[r] = (x8[r] ^ x4[r] ^ x2[r])
                 ^ (x8[(r + 1) % 4] ^ x2[(r + 1) % 4] ^ b[(r + 1) % 4])
                 ^ (x8[(r + 2) % 4] ^ x4[(r + 2) % 4] ^ b[(r + 2) % 4])
                 ^ (x8[(r + 3) % 4] ^ b[(r + 3) % 4]);
    end

    assign y = {o[0], o[1], o[2], o[3]};

endmodule

// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq: multi-cycle InvMixColumns with start/done handshake
module inv_mix_columns_seq
    import inv_mix_columns_seq_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] in,
    output logic [127:0] out,
    output logic         busy,
    output logic         done
);

    localparam col_idx_t STEP = col_idx_t'(COLS_PER_CYCLE);
    localparam col_idx_t LAST = col_idx_t'(NUM_COLS - COLS_PER_CYCLE);

    fsm_t     state, state_nxt;
    state_t   work, work_nxt;
    col_idx_t col;
    word_t    col_in [COLS_PER_CYCLE];
    word_t    col_out [COLS_PER_CYCLE];
    logic     accept, last;

    assign accept = start && state != RUN;
    assign last   = col == LAST;

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign col_in[g] = get_col(work, col + col_idx_t'(g));
        inv_mix_word u_word (.w(col_in[g]), .y(col_out[g]));
    end

    // splice the freshly transformed column group back into the working state
    always_comb begin
        work_nxt = work;
        for (int i = 0; i < COLS_PER_CYCLE; i++)
            work_nxt[127 - COL_W * int'(col + col_idx_t'(i)) -: COL_W] = col_out[i];
    end

    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nxt;

    // next state; DONE accepts a new start exactly like IDLE
    always_comb begin
        state_nxt = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
        busy      = state == RUN;
        done      = state == DONE;
    end

    // working register, column counter and result register; out only moves on completion
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            work <= '0;
            col  <= '0;
            out  <= '0;
        end else if (accept) begin
            work <= in;
            col  <= '0;
        end else if (state == RUN) begin
            work <= work_nxt;
            col  <= col + STEP;
            if (last) out <= work_nxt;
        end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb_inv_mix_columns_seq: random and directed checks of all three column widths against a matrix model
module tb_inv_mix_columns_seq;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [127:0] in = '0;
    logic [127:0] out_a [3];
    logic         busy_a [3];
    logic         done_a [3];

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    logic [127:0] m_cap [3];
    logic [127:0] m_out [3];
    int           m_cnt [3];
    logic         m_done [3];
    int           acc0 = 0;

    localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] R1 = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] V2 = 128'h4d7ebdf8_c6c6c6c6_01010101_8e4da1bc;
    localparam logic [127:0] R2 = 128'h2d26314c_c6c6c6c6_01010101_db135345;
    localparam logic [127:0] ONES = {128{1'b1}};

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << i)) u_dut (
            .clk(clk), .reset(reset), .start(start), .in(in),
            .out(out_a[i]), .busy(busy_a[i]), .done(done_a[i])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
        logic [7:0]   base [4];
        logic [7:0]   acc;
        logic [127:0] r = '0;
        if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(base[(j - row + 4) % 4], s[127 - 32 * c - 8 * j -: 8]);
                r[127 - 32 * c - 8 * row -: 8] = acc;
            end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // reference: an accepted request completes 4/cols cycles later, then shows done for one cycle
    always @(posedge clk or posedge reset)
        for (int i = 0; i < 3; i++)
            if (reset) begin
                m_cap[i] <= '0; m_out[i] <= '0; m_cnt[i] <= 0; m_done[i] <= 1'b0;
            end else if (m_cnt[i] == 0 && start) begin
                m_cap[i] <= in; m_cnt[i] <= 4 >> i; m_done[i] <= 1'b0;
                if (i == 0) acc0 <= acc0 + 1;
            end else if (m_cnt[i] > 0) begin
                m_cnt[i] <= m_cnt[i] - 1;
                m_done[i] <= m_cnt[i] == 1;
                if (m_cnt[i] == 1) m_out[i] <= mix(m_cap[i], 1'b1);
            end else m_done[i] <= 1'b0;

    // per-cycle comparison of every instance against the reference
    always @(negedge clk)
        if (chk_en)
            for (int i = 0; i < 3; i++) begin
                check($sformatf("out[%0d]", i), out_a[i], m_out[i]);
                check($sformatf("busy[%0d]", i), 128'(busy_a[i]), 128'(m_cnt[i] > 0));
                check($sformatf("done[%0d]", i), 128'(done_a[i]), 128'(m_done[i]));
                if (done_a[i]) check($sformatf("mixcol_roundtrip[%0d]", i), mix(out_a[i], 1'b0), m_cap[i]);
            end

    initial begin
        int cyc;
        check("model_imc_v1", mix(V1, 1'b1), R1);
        check("model_imc_v2", mix(V2, 1'b1), R2);
        check("model_mc_r1", mix(R1, 1'b0), V1);
        check("model_imc_ones", mix(ONES, 1'b1), ONES);
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_out[%0d]", i), out_a[i], '0);
            check($sformatf("rst_busy[%0d]", i), 128'(busy_a[i]), 128'(0));
        end
        reset = 1'b0;
        @(negedge clk); start = 1'b1; in = V1;
        @(negedge clk); start = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            if (n > 1) @(negedge clk);
            check($sformatf("c1_busy_n%0d", n), 128'(busy_a[0]), 128'(n < 5));
            check($sformatf("c1_done_n%0d", n), 128'(done_a[0]), 128'(n == 5));
        end
        check("c1_out", out_a[0], R1);
        repeat (2) @(negedge clk);
        start = 1'b1; in = V2;
        @(negedge clk); start = 1'b0;
        check("c4_busy", 128'(busy_a[2]), 128'(1));
        @(negedge clk);
        check("c4_done", 128'(done_a[2]), 128'(1));
        check("c4_out", out_a[2], R2);
        repeat (5) @(negedge clk);
        start = 1'b1; in = V1;
        @(negedge clk); in = ONES;
        for (int n = 2; n <= 10; n++) begin
            @(negedge clk);
            if (n == 5) begin
                check("hold_done1", 128'(done_a[0]), 128'(1));
                check("hold_out1", out_a[0], R1);
            end
            if (n == 6) begin
                start = 1'b0;
                check("b2b_busy", 128'(busy_a[0]), 128'(1));
            end
            if (n == 10) begin
                check("hold_done2", 128'(done_a[0]), 128'(1));
                check("hold_out2", out_a[0], ONES);
            end
        end
        repeat (5) @(negedge clk);
        start = 1'b1; in = V2;
        @(negedge clk); start = 1'b0;
        @(posedge clk); #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("arst_out[%0d]", i), out_a[i], '0);
            check($sformatf("arst_busy[%0d]", i), 128'(busy_a[i]), 128'(0));
            check($sformatf("arst_done[%0d]", i), 128'(done_a[i]), 128'(0));
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b1; in = V1;
        @(negedge clk); start = 1'b0;
        check("post_rst_accept", 128'(busy_a[0]), 128'(1));
        repeat (6) @(negedge clk);
        cyc = 0;
        while (acc0 < 1000 && cyc < 30000) begin
            @(negedge clk);
            start = 1'($urandom % 2);
            in = {$urandom, $urandom, $urandom, $urandom};
            cyc++;
        end
        if (acc0 < 1000) begin
            checks++; errors++;
            $display("FAIL random_budget got %0d starts expected 1000", acc0);
        end
        start = 1'b0;
        repeat (6) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
